mips_issue_ctrl: RTL

Issue/hazard controller for the 5-stage MIPS pipeline. It sits between ID and EX and decides each cycle whether the decoded instruction issues or a bubble is inserted. It tracks in-flight register writes in a 3-slot scoreboard (EX/MEM/WB), flushes on a taken branch, and drains the pipeline on HALT. It also keeps stall and retire counters.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/mips_src_dst_decode.sv | 63 ++++++
 rtl/mips_issue_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS issue/hazard controller: opcode encoding,
// scoreboard slot layout, controller states and bypass select codes.
package mips_pkg;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00,
    OP_ADDI = 6'h01,
    OP_SUB  = 6'h02,
    OP_SUBI = 6'h03,
    OP_AND  = 6'h04,
    OP_ANDI = 6'h05,
    OP_OR   = 6'h06,
    OP_ORI  = 6'h07,
    OP_XOR  = 6'h08,
    OP_XORI = 6'h09,
    OP_SLT  = 6'h0A,
    OP_SLTI = 6'h0B,
    OP_LWD  = 6'h0C,
    OP_STW  = 6'h0D,
    OP_BZ   = 6'h0E,
    OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10,
    OP_HALT = 6'h11
  } opcode_e;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic       valid;
    logic       wr_en;
    logic [4:0] dest;
    logic       is_load;
  } slot_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, wr_en: 1'b0, dest: 5'd0, is_load: 1'b0};

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

endpackage

// File: rtl/mips_src_dst_decode.sv
// Combinational source/destination decode of the instruction sitting in ID.
// Tells the issue controller which register fields are read, which one is
// written, and whether the instruction is a load or HALT.
module mips_src_dst_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic       rs_used,
  output logic       rt_used,
  output logic       wr_en,
  output logic [4:0] dest,
  output logic       is_load,
  output logic       is_halt
);

  // Opcode class decode; a write to $0 is architecturally a no-op.
  always_comb begin
    rs_used = 1'b0;
    rt_used = 1'b0;
    wr_en   = 1'b0;
    dest    = 5'd0;
    is_load = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
        wr_en   = 1'b1;
        dest    = rd;
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
        rs_used = 1'b1;
        wr_en   = 1'b1;
        dest    = rt;
      end
      OP_LWD: begin
        rs_used = 1'b1;
        wr_en   = 1'b1;
        dest    = rt;
        is_load = 1'b1;
      end
      OP_STW, OP_BEQ: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      OP_BZ, OP_JR: begin
        rs_used = 1'b1;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
        rs_used = 1'b0;
      end
    endcase
    if (dest == 5'd0) begin
      wr_en = 1'b0;
    end
  end

endmodule

// File: rtl/mips_issue_ctrl.sv
// Issue/hazard controller between ID and EX of the 5-stage MIPS pipeline.
// A 3-slot scoreboard (EX/MEM/WB) tracks in-flight register writes; the
// decoded instruction issues unless it reads a pending destination, a taken
// branch flushes ID, and HALT drains the pipeline into a sticky HALTED state.
// Optional build macro ISSUE_CTRL_FORWARDING_EN: only load-use stalls, other
// dependencies issue with a bypass select (youngest producer wins).
module mips_issue_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [5:0]       id_opcode_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic [4:0]       id_rd_i,
  output logic             id_ready_o,
  input  logic             ex_branch_taken_i,
  output logic             flush_o,
  output logic             fetch_en_o,
  output logic             halted_o,
  output logic [1:0]       fwd_rs_sel_o,
  output logic [1:0]       fwd_rt_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  logic       rs_used, rt_used;
  logic       dec_wr_en, dec_is_load, dec_is_halt;
  logic [4:0] dec_dest;

  mips_src_dst_decode u_decode (
    .opcode  (id_opcode_i),
    .rt      (id_rt_i),
    .rd      (id_rd_i),
    .rs_used (rs_used),
    .rt_used (rt_used),
    .wr_en   (dec_wr_en),
    .dest    (dec_dest),
    .is_load (dec_is_load),
    .is_halt (dec_is_halt)
  );

  slot_t            ex_slot_p0, mem_slot_p1, wb_slot_p2, ex_slot_next;
  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, retire_cnt_q;

  // WB is the last scoreboard stage, so its load flag has no consumer.
  logic unused_wb_load;
  assign unused_wb_load = wb_slot_p2.is_load;

  // A source hits a slot when it is read, is not $0, and the slot will write it.
  function automatic logic src_hit(input logic [4:0] src, input logic used, input slot_t slot);
    return used && (src != 5'd0) && (int'(src) < NUM_REGS) &&
           slot.valid && slot.wr_en && (slot.dest == src);
  endfunction

  logic rs_hit_ex, rs_hit_mem, rs_hit_wb;
  logic rt_hit_ex, rt_hit_mem, rt_hit_wb;
  logic hazard;

  assign rs_hit_ex  = src_hit(id_rs_i, rs_used, ex_slot_p0);
  assign rs_hit_mem = src_hit(id_rs_i, rs_used, mem_slot_p1);
  assign rs_hit_wb  = src_hit(id_rs_i, rs_used, wb_slot_p2);
  assign rt_hit_ex  = src_hit(id_rt_i, rt_used, ex_slot_p0);
  assign rt_hit_mem = src_hit(id_rt_i, rt_used, mem_slot_p1);
  assign rt_hit_wb  = src_hit(id_rt_i, rt_used, wb_slot_p2);

`ifdef ISSUE_CTRL_FORWARDING_EN
  // Youngest producer wins so the consumer sees the most recent value.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem, input logic hit_wb);
    if (hit_ex)  return FWD_EX;
    if (hit_mem) return FWD_MEM;
    if (hit_wb)  return FWD_WB;
    return FWD_RF;
  endfunction

  // Load data is not available until MEM completes, so load-use still stalls.
  assign hazard       = (rs_hit_ex || rt_hit_ex) && ex_slot_p0.is_load;
  assign fwd_rs_sel_o = fwd_sel(rs_hit_ex, rs_hit_mem, rs_hit_wb);
  assign fwd_rt_sel_o = fwd_sel(rt_hit_ex, rt_hit_mem, rt_hit_wb);
`else
  assign hazard       = rs_hit_ex || rs_hit_mem || rs_hit_wb ||
                        rt_hit_ex || rt_hit_mem || rt_hit_wb;
  assign fwd_rs_sel_o = FWD_RF;
  assign fwd_rt_sel_o = FWD_RF;
`endif

  logic in_run, candidate, issue, stall;

  // A taken branch discards the ID instruction, so it neither issues nor stalls.
  assign in_run    = (state_q == RUN);
  assign candidate = id_valid_i && !ex_branch_taken_i;
  assign issue     = in_run && candidate && !hazard;
  assign stall     = in_run && candidate && hazard;
  assign flush_o   = ex_branch_taken_i;

  // Controller next state and per-state outputs.
  always_comb begin
    state_d    = state_q;
    id_ready_o = 1'b0;
    fetch_en_o = 1'b0;
    halted_o   = 1'b0;
    case (state_q)
      RUN: begin
        id_ready_o = issue;
        fetch_en_o = !stall && !(issue && dec_is_halt);
        if (issue && dec_is_halt) begin
          state_d = DRAIN;
        end
      end
      // EX and MEM empty means WB retires this cycle and everything is gone
      // after the edge.
      DRAIN: begin
        if (!ex_slot_p0.valid && !mem_slot_p1.valid) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        halted_o = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Issued instruction enters EX; HALT and non-issue cycles insert a bubble.
  always_comb begin
    ex_slot_next = SLOT_EMPTY;
    if (issue && !dec_is_halt) begin
      ex_slot_next.valid   = 1'b1;
      ex_slot_next.wr_en   = dec_wr_en;
      ex_slot_next.dest    = dec_dest;
      ex_slot_next.is_load = dec_is_load;
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Scoreboard shift EX -> MEM -> WB; reset only invalidates the slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_slot_p0.valid  <= 1'b0;
      mem_slot_p1.valid <= 1'b0;
      wb_slot_p2.valid  <= 1'b0;
    end else begin
      ex_slot_p0  <= ex_slot_next;
      mem_slot_p1 <= ex_slot_p0;
      wb_slot_p2  <= mem_slot_p1;
    end
  end

  // Stall and retire counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (wb_slot_p2.valid) begin
        retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign retire_cnt_o = retire_cnt_q;

endmodule
